// File: rtl/vpu_opnd_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// vpu_opnd_fetch_ctrl
//
// Operand fetch controller between the VPU request FIFO and the banked operand
// SRAM. One 136-bit instruction is accepted at a time. Its source operand
// addresses are decoded into bank and row, reads are scheduled on each bank's
// single read port (conflicts within a bank are serialised, different banks
// read in parallel), and the gathered source vectors are handed to the vector
// lanes together with opcode and destination address.
//
// Instruction layout: opcode[135:128] src2[127:96] src1[95:64] src0[63:32]
// dst0[31:0]. Operand address: bank = addr[10:9], row = addr[20:11].
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   instr_valid_i/ready_o/i    instruction handshake and payload
//   sram_ren_o                 per-bank read enable
//   sram_raddr_o               per-bank row, bank b at [b*10 +: 10] (0 when idle)
//   sram_rdata_i               per-bank read data, valid one cycle after ren
//   opnd_valid_o/ready_i       operand bundle handshake
//   opnd_data_o                src0 [511:0], src1 [1023:512], src2 [1535:1024]
//   opnd_opcode_o, opnd_dst_o  opcode and dst0 address of the bundle
//   busy_o                     high whenever the FSM is not in IDLE
//
// Build option
//   VPU_OPND_MERGE_EN : when defined, pending sources that hit the same bank
//                       and row as a granted source share its single read.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | ready for a new instruction
// ISSUE | driving one read per bank per cycle until no source is pending
// WAIT  | capturing data returned by the last ISSUE cycle
// OUT   | operand bundle valid, held until the consumer takes it
// ---------------------------------------------------------------------------
module vpu_opnd_fetch_ctrl #(
  parameter int SRAM_BANK_CNT      = 4,
  parameter int SRAM_BANK_DEPTH    = 1024,
  parameter int SRAM_DATA_WIDTH    = 512,
  parameter int OPERAND_ADDR_WIDTH = 32,
  parameter int INSTR_WIDTH        = 136
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   instr_valid_i,
  output logic                                   instr_ready_o,
  input  logic [INSTR_WIDTH-1:0]                 instr_i,
  output logic [SRAM_BANK_CNT-1:0]               sram_ren_o,
  output logic [SRAM_BANK_CNT*10-1:0]            sram_raddr_o,
  input  logic [SRAM_BANK_CNT*SRAM_DATA_WIDTH-1:0] sram_rdata_i,
  output logic                                   opnd_valid_o,
  input  logic                                   opnd_ready_i,
  output logic [3*SRAM_DATA_WIDTH-1:0]           opnd_data_o,
  output logic [7:0]                             opnd_opcode_o,
  output logic [31:0]                            opnd_dst_o,
  output logic                                   busy_o
);

  localparam int BANK_W  = $clog2(SRAM_BANK_CNT);
  localparam int ROW_W   = $clog2(SRAM_BANK_DEPTH);
  localparam int BANK_LSB = 9;
  localparam int ROW_LSB  = BANK_LSB + BANK_W;
  localparam int DW       = SRAM_DATA_WIDTH;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, OUT} state_t;

  state_t                         state_q;
  logic [2:0]                     pend_q;   // sources not yet read
  logic [2:0]                     iss_q;    // sources being read this cycle
  logic [2:0]                     cap_q;    // sources whose data is on sram_rdata_i now
  logic [BANK_W-1:0]              bank_q [3];
  logic [ROW_W-1:0]               row_q  [3];
  logic [7:0]                     opcode_q;
  logic [31:0]                    dst_q;
  logic [DW-1:0]                  opnd_q [3];
  logic [SRAM_BANK_CNT-1:0]       ren_q;
  logic [SRAM_BANK_CNT*10-1:0]    raddr_q;

  // Decode of the incoming instruction
  logic [OPERAND_ADDR_WIDTH-1:0]  src_new  [3];
  logic [BANK_W-1:0]              bank_new [3];
  logic [ROW_W-1:0]               row_new  [3];
  logic [7:0]                     opcode_new;
  logic [2:0]                     mask_new;

  assign src_new[0] = instr_i[63:32];
  assign src_new[1] = instr_i[95:64];
  assign src_new[2] = instr_i[127:96];
  assign opcode_new = instr_i[135:128];

  always_comb begin
    for (int s = 0; s < 3; s++) begin
      bank_new[s] = src_new[s][ROW_LSB-1:BANK_LSB];
      row_new[s]  = src_new[s][ROW_LSB+ROW_W-1:ROW_LSB];
    end
  end

  // Two-source ops (IADD, ISUB, FADD) leave src2 unread and zero
  assign mask_new = (opcode_new == 8'h01 || opcode_new == 8'h02 || opcode_new == 8'h03)
                    ? 3'b011 : 3'b111;

  // Per-bank grant. In IDLE the grant is computed from the incoming
  // instruction so the first read can be registered on the accepting edge.
  logic [2:0]               sel_mask;
  logic [BANK_W-1:0]        sel_bank [3];
  logic [ROW_W-1:0]         sel_row  [3];
  logic [SRAM_BANK_CNT-1:0] ren_c;
  logic [ROW_W-1:0]         row_c [SRAM_BANK_CNT];
  logic [2:0]               gnt_c;
  logic [SRAM_BANK_CNT*10-1:0] raddr_c;

  always_comb begin
    sel_mask = pend_q;
    for (int s = 0; s < 3; s++) begin
      sel_bank[s] = bank_q[s];
      sel_row[s]  = row_q[s];
    end
    if (state_q == IDLE) begin
      sel_mask = mask_new;
      for (int s = 0; s < 3; s++) begin
        sel_bank[s] = bank_new[s];
        sel_row[s]  = row_new[s];
      end
    end

    ren_c   = '0;
    gnt_c   = '0;
    raddr_c = '0;
    for (int b = 0; b < SRAM_BANK_CNT; b++) begin
      row_c[b] = '0;
    end

    // lowest-indexed pending source wins its bank
    for (int b = 0; b < SRAM_BANK_CNT; b++) begin
      for (int s = 0; s < 3; s++) begin
        if (sel_mask[s] && sel_bank[s] == BANK_W'(b) && !ren_c[b]) begin
          ren_c[b] = 1'b1;
          row_c[b] = sel_row[s];
          gnt_c[s] = 1'b1;
        end
      end
    end

`ifdef VPU_OPND_MERGE_EN
    // piggy-back sources hitting the row already being read in their bank
    for (int s = 0; s < 3; s++) begin
      if (sel_mask[s] && ren_c[sel_bank[s]] && sel_row[s] == row_c[sel_bank[s]]) begin
        gnt_c[s] = 1'b1;
      end
    end
`endif

    for (int b = 0; b < SRAM_BANK_CNT; b++) begin
      raddr_c[b*10 +: 10] = 10'(row_c[b]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      pend_q   <= '0;
      iss_q    <= '0;
      cap_q    <= '0;
      opcode_q <= '0;
      dst_q    <= '0;
      ren_q    <= '0;
      raddr_q  <= '0;
      for (int s = 0; s < 3; s++) begin
        bank_q[s] <= '0;
        row_q[s]  <= '0;
        opnd_q[s] <= '0;
      end
    end else begin
      cap_q <= iss_q;
      for (int s = 0; s < 3; s++) begin
        if (cap_q[s]) begin
          opnd_q[s] <= sram_rdata_i[int'(bank_q[s])*DW +: DW];
        end
      end

      case (state_q)
        IDLE: begin
          if (instr_valid_i) begin
            opcode_q <= opcode_new;
            dst_q    <= instr_i[31:0];
            for (int s = 0; s < 3; s++) begin
              bank_q[s] <= bank_new[s];
              row_q[s]  <= row_new[s];
              opnd_q[s] <= '0;
            end
            pend_q  <= mask_new & ~gnt_c;
            iss_q   <= gnt_c;
            ren_q   <= ren_c;
            raddr_q <= raddr_c;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          // pend_q already excludes this cycle's grants
          if (pend_q == 3'b000) begin
            ren_q   <= '0;
            raddr_q <= '0;
            iss_q   <= '0;
            state_q <= WAIT;
          end else begin
            pend_q  <= pend_q & ~gnt_c;
            iss_q   <= gnt_c;
            ren_q   <= ren_c;
            raddr_q <= raddr_c;
          end
        end
        WAIT: begin
          state_q <= OUT;
        end
        OUT: begin
          if (opnd_ready_i) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign instr_ready_o = (state_q == IDLE);
  assign opnd_valid_o  = (state_q == OUT);
  assign busy_o        = (state_q != IDLE);
  assign sram_ren_o    = ren_q;
  assign sram_raddr_o  = raddr_q;
  assign opnd_data_o   = {opnd_q[2], opnd_q[1], opnd_q[0]};
  assign opnd_opcode_o = opcode_q;
  assign opnd_dst_o    = dst_q;

  // Address bits outside bank/row are intentionally ignored
  logic unused_instr;
  assign unused_instr = ^instr_i;

endmodule

// File: tb/tb_vpu_opnd_fetch_ctrl.sv
module tb_vpu_opnd_fetch_ctrl;

  logic           clk;
  logic           rst_n;
  logic           instr_valid_i;
  logic           instr_ready_o;
  logic [135:0]   instr_i;
  logic [3:0]     sram_ren_o;
  logic [39:0]    sram_raddr_o;
  logic [2047:0]  sram_rdata_i;
  logic           opnd_valid_o;
  logic           opnd_ready_i;
  logic [1535:0]  opnd_data_o;
  logic [7:0]     opnd_opcode_o;
  logic [31:0]    opnd_dst_o;
  logic           busy_o;

  int checks = 0;
  int errors = 0;

  vpu_opnd_fetch_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .instr_valid_i (instr_valid_i),
    .instr_ready_o (instr_ready_o),
    .instr_i       (instr_i),
    .sram_ren_o    (sram_ren_o),
    .sram_raddr_o  (sram_raddr_o),
    .sram_rdata_i  (sram_rdata_i),
    .opnd_valid_o  (opnd_valid_o),
    .opnd_ready_i  (opnd_ready_i),
    .opnd_data_o   (opnd_data_o),
    .opnd_opcode_o (opnd_opcode_o),
    .opnd_dst_o    (opnd_dst_o),
    .busy_o        (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [511:0] pat(input int b, input logic [9:0] row);
    logic [31:0] w;
    w = {4'hA, 2'b00, 2'(b), 14'h0, row};
    return {16{w}};
  endfunction

  // SRAM model: one-cycle read latency, junk when not read
  always @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (sram_ren_o[b])
        sram_rdata_i[b*512 +: 512] <= pat(b, sram_raddr_o[b*10 +: 10]);
      else
        sram_rdata_i[b*512 +: 512] <= {16{32'hDEAD_BEEF}};
    end
  end

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Drive one instruction during cycle T; returns at the negedge of T+1
  task automatic send(input logic [7:0] op, input logic [31:0] s0, input logic [31:0] s1,
                      input logic [31:0] s2, input logic [31:0] d);
    chk("send_ready", 512'(instr_ready_o), 512'(1));
    instr_i       = {op, s2, s1, s0, d};
    instr_valid_i = 1'b1;
    @(negedge clk);
    instr_valid_i = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"}, 512'(instr_ready_o), 512'(1));
    chk({tag, "_valid"}, 512'(opnd_valid_o), 512'(0));
    chk({tag, "_ren"},   512'(sram_ren_o), 512'(0));
    chk({tag, "_raddr"}, 512'(sram_raddr_o), 512'(0));
    chk({tag, "_d0"},    opnd_data_o[511:0], 512'(0));
    chk({tag, "_d1"},    opnd_data_o[1023:512], 512'(0));
    chk({tag, "_d2"},    opnd_data_o[1535:1024], 512'(0));
    chk({tag, "_opc"},   512'(opnd_opcode_o), 512'(0));
    chk({tag, "_dst"},   512'(opnd_dst_o), 512'(0));
    chk({tag, "_busy"},  512'(busy_o), 512'(0));
  endtask

  initial begin
    rst_n         = 1'b0;
    instr_valid_i = 1'b0;
    instr_i       = '0;
    opnd_ready_i  = 1'b1;
    sram_rdata_i  = '0;
    step();
    chk_reset_outputs("rst");
    step();
    rst_n = 1'b1;
    step();

    // No conflict: IADD, banks 0 and 1, row 0
    send(8'h01, 32'h0000_0000, 32'h0000_0200, 32'hFFFF_FFFF, 32'h0000_1234);
    chk("nc_ren_t1",   512'(sram_ren_o), 512'(4'b0011));
    chk("nc_raddr_t1", 512'(sram_raddr_o), 512'(0));
    chk("nc_busy_t1",  512'(busy_o), 512'(1));
    chk("nc_ready_t1", 512'(instr_ready_o), 512'(0));
    step();
    chk("nc_ren_t2",   512'(sram_ren_o), 512'(0));
    chk("nc_valid_t2", 512'(opnd_valid_o), 512'(0));
    step();
    chk("nc_valid_t3", 512'(opnd_valid_o), 512'(1));
    chk("nc_d0", opnd_data_o[511:0], pat(0, 10'd0));
    chk("nc_d1", opnd_data_o[1023:512], pat(1, 10'd0));
    chk("nc_d2", opnd_data_o[1535:1024], 512'(0));
    chk("nc_opc", 512'(opnd_opcode_o), 512'(8'h01));
    chk("nc_dst", 512'(opnd_dst_o), 512'(32'h0000_1234));
    step();
    chk("nc_valid_done", 512'(opnd_valid_o), 512'(0));
    chk("nc_busy_done",  512'(busy_o), 512'(0));

    // Conflict: FADD, bank 0 rows 0 and 1
    send(8'h03, 32'h0000_0000, 32'h0000_0800, 32'h0, 32'h0000_00AA);
    chk("cf_ren_t1",   512'(sram_ren_o), 512'(4'b0001));
    chk("cf_raddr_t1", 512'(sram_raddr_o), 512'(0));
    step();
    chk("cf_ren_t2",   512'(sram_ren_o), 512'(4'b0001));
    chk("cf_raddr_t2", 512'(sram_raddr_o), 512'(40'd1));
    step();
    chk("cf_ren_t3",   512'(sram_ren_o), 512'(0));
    chk("cf_valid_t3", 512'(opnd_valid_o), 512'(0));
    step();
    chk("cf_valid_t4", 512'(opnd_valid_o), 512'(1));
    chk("cf_d0", opnd_data_o[511:0], pat(0, 10'd0));
    chk("cf_d1", opnd_data_o[1023:512], pat(0, 10'd1));
    chk("cf_d2", opnd_data_o[1535:1024], 512'(0));
    step();

    // Three sources, all in bank 2, rows 0..2
    send(8'h10, 32'h0000_0400, 32'h0000_0C00, 32'h0000_1400, 32'h0000_0777);
    chk("b2_ren_t1",   512'(sram_ren_o), 512'(4'b0100));
    chk("b2_raddr_t1", 512'(sram_raddr_o), 512'(40'd0 << 20));
    step();
    chk("b2_ren_t2",   512'(sram_ren_o), 512'(4'b0100));
    chk("b2_raddr_t2", 512'(sram_raddr_o), 512'(40'd1 << 20));
    step();
    chk("b2_ren_t3",   512'(sram_ren_o), 512'(4'b0100));
    chk("b2_raddr_t3", 512'(sram_raddr_o), 512'(40'd2 << 20));
    step();
    chk("b2_ren_t4",   512'(sram_ren_o), 512'(0));
    chk("b2_valid_t4", 512'(opnd_valid_o), 512'(0));
    step();
    chk("b2_valid_t5", 512'(opnd_valid_o), 512'(1));
    chk("b2_d0", opnd_data_o[511:0], pat(2, 10'd0));
    chk("b2_d1", opnd_data_o[1023:512], pat(2, 10'd1));
    chk("b2_d2", opnd_data_o[1535:1024], pat(2, 10'd2));
    chk("b2_opc", 512'(opnd_opcode_o), 512'(8'h10));
    step();

    // Identical addresses: bank 0 row 2 for both sources
    send(8'h01, 32'h0000_1000, 32'h0000_1000, 32'h0, 32'h0000_0042);
    chk("mg_ren_t1",   512'(sram_ren_o), 512'(4'b0001));
    chk("mg_raddr_t1", 512'(sram_raddr_o), 512'(40'd2));
`ifdef VPU_OPND_MERGE_EN
    step();
    chk("mg_ren_t2",   512'(sram_ren_o), 512'(0));
    step();
`else
    step();
    chk("mg_ren_t2",   512'(sram_ren_o), 512'(4'b0001));
    chk("mg_raddr_t2", 512'(sram_raddr_o), 512'(40'd2));
    step();
    chk("mg_valid_t3", 512'(opnd_valid_o), 512'(0));
    step();
`endif
    chk("mg_valid", 512'(opnd_valid_o), 512'(1));
    chk("mg_d0", opnd_data_o[511:0], pat(0, 10'd2));
    chk("mg_d1", opnd_data_o[1023:512], pat(0, 10'd2));
    chk("mg_d2", opnd_data_o[1535:1024], 512'(0));
    step();

    // Backpressure: bundle held, second instruction not accepted
    opnd_ready_i = 1'b0;
    send(8'h02, 32'h0000_0200, 32'h0000_0600, 32'h0, 32'h0000_5555);
    chk("bp_ren_t1", 512'(sram_ren_o), 512'(4'b1010));
    step();
    step();
    instr_i       = {8'h10, 32'h0000_0400, 32'h0000_0C00, 32'h0000_1400, 32'h0000_9999};
    instr_valid_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk("bp_valid", 512'(opnd_valid_o), 512'(1));
      chk("bp_ready", 512'(instr_ready_o), 512'(0));
      chk("bp_ren",   512'(sram_ren_o), 512'(0));
      chk("bp_d0",    opnd_data_o[511:0], pat(1, 10'd0));
      chk("bp_d1",    opnd_data_o[1023:512], pat(3, 10'd0));
      chk("bp_dst",   512'(opnd_dst_o), 512'(32'h0000_5555));
      step();
    end
    instr_valid_i = 1'b0;
    opnd_ready_i  = 1'b1;
    chk("bp_valid_rel", 512'(opnd_valid_o), 512'(1));
    step();
    chk("bp_valid_done", 512'(opnd_valid_o), 512'(0));
    chk("bp_ready_done", 512'(instr_ready_o), 512'(1));
    chk("bp_ren_done",   512'(sram_ren_o), 512'(0));
    chk("bp_dst_kept",   512'(opnd_dst_o), 512'(32'h0000_5555));
    chk("bp_opc_kept",   512'(opnd_opcode_o), 512'(8'h02));

    // Reset during ISSUE, then a normal instruction
    send(8'h10, 32'h0000_0400, 32'h0000_0C00, 32'h0000_1400, 32'h0000_0777);
    step();
    chk("ri_ren_t2", 512'(sram_ren_o), 512'(4'b0100));
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("ri");
    step();
    rst_n = 1'b1;
    step();
    send(8'h01, 32'h0000_0600, 32'h0000_2A00, 32'h0, 32'h0000_0BAD);
    chk("ar_ren_t1",   512'(sram_ren_o), 512'(4'b1010));
    chk("ar_raddr_t1", 512'(sram_raddr_o), 512'(40'd5 << 10));
    step();
    chk("ar_valid_t2", 512'(opnd_valid_o), 512'(0));
    step();
    chk("ar_valid_t3", 512'(opnd_valid_o), 512'(1));
    chk("ar_d0", opnd_data_o[511:0], pat(3, 10'd0));
    chk("ar_d1", opnd_data_o[1023:512], pat(1, 10'd5));
    chk("ar_d2", opnd_data_o[1535:1024], 512'(0));
    chk("ar_dst", 512'(opnd_dst_o), 512'(32'h0000_0BAD));
    step();
    chk("ar_valid_done", 512'(opnd_valid_o), 512'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
